// File: rtl/keypad_hit_frontend_pkg.sv
// rtl/keypad_hit_frontend_pkg.sv - shared types and defaults for the keypad hit front end
package keypad_hit_frontend_pkg;

  localparam int DEFAULT_NUM_KEYS        = 8;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    KEY_IDLE         = 2'd0,
    KEY_PRESS_WAIT   = 2'd1,
    KEY_HELD         = 2'd2,
    KEY_RELEASE_WAIT = 2'd3
  } key_state_t;

  // Wide enough to hold DEBOUNCE_CYCLES itself, the saturation value.
  function automatic int cnt_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/keypad_hit_frontend_if.sv
// rtl/keypad_hit_frontend_if.sv - raw key inputs and debounced press/level outputs
interface keypad_hit_frontend_if
  import keypad_hit_frontend_pkg::*;
#(
  parameter int NUM_KEYS = DEFAULT_NUM_KEYS
);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] keypad;
  logic [NUM_KEYS-1:0] key_level;
  logic                any_press;

  modport master (
    output key_raw,
    input  keypad,
    input  key_level,
    input  any_press
  );

  modport slave (
    input  key_raw,
    output keypad,
    output key_level,
    output any_press
  );

endinterface

// File: rtl/keypad_hit_frontend_key_debounce_cell.sv
// rtl/keypad_hit_frontend_key_debounce_cell.sv - per-key synchronizer, debounce FSM and press pulse
module key_debounce_cell
  import keypad_hit_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)(
  input  logic CLK,
  input  logic RESET,
  input  logic key_raw,
  output logic keypad,
  output logic key_level
);

  localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_meta;
  logic             sync_q;
  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_done;
  logic             keypad_nxt;
  logic             key_level_nxt;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      state     <= KEY_IDLE;
      cnt       <= '0;
      keypad    <= 1'b0;
      key_level <= 1'b0;
    end else begin
      sync_meta <= key_raw;
      sync_q    <= sync_meta;
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      keypad    <= keypad_nxt;
      key_level <= key_level_nxt;
    end
  end

  // The current sample is the DEBOUNCE_CYCLES-th stable one when cnt already holds one less.
  assign stable_done = (cnt >= CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      KEY_IDLE: begin
        if (sync_q) begin
          state_nxt = KEY_PRESS_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      KEY_PRESS_WAIT: begin
        if (!sync_q) begin
          state_nxt = KEY_IDLE;
          cnt_nxt   = '0;
        end else if (stable_done) begin
          state_nxt = KEY_HELD;
          cnt_nxt   = CNT_FULL;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      KEY_HELD: begin
        if (!sync_q) begin
          state_nxt = KEY_RELEASE_WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end
      KEY_RELEASE_WAIT: begin
        if (sync_q) begin
          state_nxt = KEY_HELD;
          cnt_nxt   = '0;
        end else if (stable_done) begin
          state_nxt = KEY_IDLE;
          cnt_nxt   = CNT_FULL;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = KEY_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Only a fresh press pulses; bouncing back from RELEASE_WAIT keeps the key held silently.
  always_comb begin
    keypad_nxt    = (state == KEY_PRESS_WAIT) && (state_nxt == KEY_HELD);
    key_level_nxt = (state_nxt == KEY_HELD) || (state_nxt == KEY_RELEASE_WAIT);
  end

endmodule

// File: rtl/keypad_hit_frontend.sv
// rtl/keypad_hit_frontend.sv - array of independent debounced keys with an any-press flag
module keypad_hit_frontend
  import keypad_hit_frontend_pkg::*;
#(
  parameter int NUM_KEYS        = DEFAULT_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
)(
  input  logic                  CLK,
  input  logic                  RESET,
  keypad_hit_frontend_if.slave  keys
);

  logic [NUM_KEYS-1:0] keypad_w;
  logic [NUM_KEYS-1:0] key_level_w;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .CLK       (CLK),
      .RESET     (RESET),
      .key_raw   (keys.key_raw[i]),
      .keypad    (keypad_w[i]),
      .key_level (key_level_w[i])
    );
  end

  assign keys.keypad    = keypad_w;
  assign keys.key_level = key_level_w;
  assign keys.any_press = |keypad_w;

endmodule

// File: tb/tb_keypad_hit_frontend.sv
// tb/tb_keypad_hit_frontend.sv - scoreboard bench for the keypad hit front end at DEBOUNCE_CYCLES=4
module tb_keypad_hit_frontend;

  localparam int NK = 8;
  localparam int DB = 4;
  localparam int LAT = DB + 2;

  typedef struct {
    int          cyc;
    logic [NK-1:0] keypad;
    logic [NK-1:0] level;
  } exp_t;

  logic CLK;
  logic RESET;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  keypad_hit_frontend_if #(.NUM_KEYS(NK)) bus ();

  keypad_hit_frontend #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .keys  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    bus.key_raw = '0;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int r = 0; r < 6; r++) begin
      RESET = 1'b1;
      bus.key_raw = 8'hFF;
      e.cyc = r; e.keypad = '0; e.level = '0;
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL reset_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL reset_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== 1'b0) begin errors++; $display("FAIL reset_any cyc=%0d got=%b exp=0", e.cyc, bus.any_press); end
      @(posedge CLK); #1;
    end
    for (int c = 0; c < 12; c++) begin
      RESET = 1'b0;
      bus.key_raw = 8'hFF;
      e.cyc = c;
      e.keypad = (c == LAT) ? 8'hFF : 8'h00;
      e.level  = (c >= LAT) ? 8'hFF : 8'h00;
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL held_through_reset_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL held_through_reset_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL held_through_reset_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_single_press();
    exp_t e;
    for (int c = 0; c < 32; c++) begin
      bus.key_raw = (c < 20) ? 8'h01 : 8'h00;
      e.cyc = c;
      e.keypad = (c == LAT) ? 8'h01 : 8'h00;
      e.level  = (c >= LAT && c < 20 + LAT) ? 8'h01 : 8'h00;
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL single_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL single_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL single_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
  endtask

  // Key 3 is one stable cycle short; key 4 is high for exactly the debounce length.
  task automatic test_glitch();
    exp_t e;
    for (int c = 0; c < 36; c++) begin
      bus.key_raw = '0;
      bus.key_raw[3] = (c < DB - 1);
      bus.key_raw[4] = (c >= 20 && c < 20 + DB);
      e.cyc = c;
      e.keypad = '0;
      e.level  = '0;
      e.keypad[4] = (c == 20 + LAT);
      e.level[4]  = (c >= 20 + LAT && c < 20 + DB + LAT);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL glitch_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL glitch_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL glitch_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_simultaneous();
    exp_t e;
    for (int c = 0; c < 22; c++) begin
      bus.key_raw = (c < 12) ? 8'h81 : 8'h00;
      e.cyc = c;
      e.keypad = (c == LAT) ? 8'h81 : 8'h00;
      e.level  = (c >= LAT && c < 12 + LAT) ? 8'h81 : 8'h00;
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL simul_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL simul_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL simul_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
  endtask

  // Key 2: 2-cycle and 3-cycle release glitches, then a clean release.
  task automatic test_release_glitch();
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      bus.key_raw = '0;
      bus.key_raw[2] = (c < 12) || (c >= 14 && c < 18) || (c >= 21 && c < 28);
      e.cyc = c;
      e.keypad = '0;
      e.level  = '0;
      e.keypad[2] = (c == LAT);
      e.level[2]  = (c >= LAT && c < 28 + LAT);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL rel_glitch_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL rel_glitch_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL rel_glitch_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
  endtask

  // Staggered presses on keys 0/1 plus a long hold on key 6.
  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 60; c++) begin
      bus.key_raw = '0;
      bus.key_raw[0] = 1'b1;
      bus.key_raw[1] = (c >= 2 && c < 30);
      bus.key_raw[6] = 1'b1;
      e.cyc = c;
      e.keypad = '0;
      e.level  = '0;
      e.keypad[0] = (c == LAT);
      e.keypad[6] = (c == LAT);
      e.keypad[1] = (c == 2 + LAT);
      e.level[0]  = (c >= LAT);
      e.level[6]  = (c >= LAT);
      e.level[1]  = (c >= 2 + LAT && c < 30 + LAT);
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL b2b_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL b2b_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL b2b_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
  endtask

  // Key 5 reset mid-debounce (cycle 4); key 1 reset mid-hold (cycle 10), in separate passes.
  task automatic test_reset_abort();
    exp_t e;
    for (int c = 0; c < 20; c++) begin
      RESET = (c == 4);
      bus.key_raw = 8'h20;
      e.cyc = c;
      e.keypad = (c == 5 + LAT) ? 8'h20 : 8'h00;
      e.level  = (c >= 5 + LAT) ? 8'h20 : 8'h00;
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL abort_press_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL abort_press_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL abort_press_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
    apply_reset();
    for (int c = 0; c < 26; c++) begin
      RESET = (c == 10);
      bus.key_raw = 8'h02;
      e.cyc = c;
      e.keypad = (c == LAT || c == 11 + LAT) ? 8'h02 : 8'h00;
      e.level  = ((c >= LAT && c <= 10) || c >= 11 + LAT) ? 8'h02 : 8'h00;
      exp_q.push_back(e);
      @(negedge CLK);
      e = exp_q.pop_front();
      checks++;
      if (bus.keypad !== e.keypad) begin errors++; $display("FAIL abort_hold_keypad cyc=%0d got=%h exp=%h", e.cyc, bus.keypad, e.keypad); end
      checks++;
      if (bus.key_level !== e.level) begin errors++; $display("FAIL abort_hold_level cyc=%0d got=%h exp=%h", e.cyc, bus.key_level, e.level); end
      checks++;
      if (bus.any_press !== (|e.keypad)) begin errors++; $display("FAIL abort_hold_any cyc=%0d got=%b exp=%b", e.cyc, bus.any_press, |e.keypad); end
      @(posedge CLK); #1;
    end
    RESET = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    bus.key_raw = 8'hFF;
    @(posedge CLK); #1;
    test_reset();
    apply_reset();
    test_single_press();
    apply_reset();
    test_glitch();
    apply_reset();
    test_simultaneous();
    apply_reset();
    test_release_glitch();
    apply_reset();
    test_back_to_back();
    apply_reset();
    test_reset_abort();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
